aes128_encrypt_iter: RTL

- Iterative AES-128 encryption engine. It is the forward-direction counterpart of the team's combinational decrypt datapath.
- Computes one cipher round per clock and expands round keys on the fly (K0..K10), so no 1408-bit key table is needed.
- Sits behind the AXI-Lite register wrapper in aes_ip and uses a valid/ready handshake on both input and output.
- Ciphertext it produces must decrypt back to the original plaintext through the existing Decrypt path.

---
 rtl/aes128_encrypt_iter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion (optional macro AES_LAST_KEY_OUT_EN)

// Round-key XOR stage shared with the decrypt datapath.
module addroundkey (
    input  logic [127:0] data,
    input  logic [127:0] round_key,
    output logic [127:0] result
);
    assign result = data ^ round_key;
endmodule

module aes128_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] cipher_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
`ifdef AES_LAST_KEY_OUT_EN
    ,
    output logic [127:0] last_round_key
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // Forward S-box, byte 0x00 in the top byte of the vector.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x lives at bit offset 8*(255-x) == {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Round constant, indexed directly by the 1-based round number.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state, state_next;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   rnd;

    logic [127:0] sub_shift;
    logic [127:0] mixed;
    logic [127:0] round_data;
    logic [127:0] round_result;
    logic [127:0] init_state;
    logic [127:0] rk_next;
    logic [31:0]  key_temp;
    logic         last_round;

    assign last_round = (rnd == NR_L);

    // SubBytes + ShiftRows: output byte (row r, col c) takes input byte (r, (c+r) mod 4).
    always_comb begin
        sub_shift = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[127 - 8*(4*c + r) -: 8] = sbox(st[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
    end

    // MixColumns on all four columns; bypassed in the final round.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_column(sub_shift[127 - 32*c -: 32]);
        end
        round_data = last_round ? sub_shift : mixed;
    end

    // Next round key: RotWord/SubWord/Rcon on the last word, then the XOR chain.
    always_comb begin
        key_temp = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
                 ^ {rcon(rnd), 24'h000000};
        rk_next[127:96] = rk[127:96] ^ key_temp;
        rk_next[95:64]  = rk[95:64]  ^ rk_next[127:96];
        rk_next[63:32]  = rk[63:32]  ^ rk_next[95:64];
        rk_next[31:0]   = rk[31:0]   ^ rk_next[63:32];
    end

    addroundkey u_ark_init (
        .data      (plaintext),
        .round_key (cipher_key),
        .result    (init_state)
    );

    addroundkey u_ark_round (
        .data      (round_data),
        .round_key (rk_next),
        .result    (round_result)
    );

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (last_round) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Cipher state, round key, round counter and result registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st             <= '0;
            rk             <= '0;
            rnd            <= '0;
            ciphertext     <= '0;
`ifdef AES_LAST_KEY_OUT_EN
            last_round_key <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st  <= init_state;
                        rk  <= cipher_key;
                        rnd <= 4'd1;
                    end
                end
                ROUND: begin
                    st <= round_result;
                    rk <= rk_next;
                    if (rnd < NR_L) begin
                        rnd <= rnd + 4'd1;
                    end
                    if (last_round) begin
                        ciphertext     <= round_result;
`ifdef AES_LAST_KEY_OUT_EN
                        last_round_key <= rk_next;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
